conv_wb_slave_if: RTL and testbench

CONV_WB_SLAVE_IF -- requirements
Module: conv_wb_slave_if

---
 rtl/conv_wb_slave_if_if.sv | 23 ++
 rtl/conv_wb_slave_if.sv | 205 ++++++++++++++++++++
 tb/tb_conv_wb_slave_if.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_wb_slave_if_if.sv
// Wishbone slave-side bus bundle for the convolution core register/memory window.
// Combinational bundle only: no storage, no latency.
// Backpressure is the slave's ack; the master holds cyc/stb until it sees ack.
interface conv_wb_slave_if_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/conv_wb_slave_if.sv
// Wishbone slave exposing control regs, image/kernel write ports and result read port.
// Latency: write acked 1 cycle after accept, read acked 2 cycles after accept.
// Backpressure: one transaction in flight; nothing accepted while in RD_WAIT or ACK.
module conv_wb_slave_if #(
  parameter logic [7:0] BASE_HI         = 8'h30,
  parameter int         INST_NO         = 0,
  parameter int         IMG_ADDR_WIDTH  = 5,
  parameter int         RSLT_ADDR_WIDTH = 6
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  conv_wb_slave_if_if.slave          wb,
  output logic                       start_o,
  output logic                       soft_rst_o,
  output logic [31:0]                cfg1_o,
  output logic [31:0]                cfg2_o,
  input  logic                       done_i,
  output logic                       img_we_o,
  output logic                       kern_we_o,
  output logic [IMG_ADDR_WIDTH-1:0]  img_addr_o,
  output logic [IMG_ADDR_WIDTH-1:0]  kern_addr_o,
  output logic [23:0]                mem_wdata_o,
  output logic [RSLT_ADDR_WIDTH-1:0] rslt_addr_o,
  input  logic [7:0]                 rslt_rdata_i
);

  localparam logic [7:0]  MY_HI      = BASE_HI + 8'(INST_NO);
  localparam int unsigned IMG_DEPTH  = 32'd1 << IMG_ADDR_WIDTH;
  localparam int unsigned RSLT_DEPTH = 32'd1 << RSLT_ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ACK} state_e;

  state_e                     state_q, state_d;
  logic [31:0]                dat_q, dat_d;
  logic                       start_q, start_d;
  logic                       soft_rst_q, soft_rst_d;
  logic [31:0]                cfg1_q, cfg1_d;
  logic [31:0]                cfg2_q, cfg2_d;
  logic                       img_we_q, img_we_d;
  logic                       kern_we_q, kern_we_d;
  logic [IMG_ADDR_WIDTH-1:0]  img_addr_q, img_addr_d;
  logic [IMG_ADDR_WIDTH-1:0]  kern_addr_q, kern_addr_d;
  logic [23:0]                mem_wdata_q, mem_wdata_d;
  logic [RSLT_ADDR_WIDTH-1:0] rslt_addr_q, rslt_addr_d;
  logic [1:0]                 rd_region_q, rd_region_d;
  logic [5:0]                 rd_idx_q, rd_idx_d;

  logic        sel_hit;
  logic [1:0]  region;
  logic [5:0]  idx;
  logic [31:0] idx_ext;
  logic [31:0] rd_idx_ext;
  logic [31:0] wmask;
  logic        unused_adr;

  // Only the upper address byte is decoded; bits inside a word and above the region are don't-care.
  assign unused_adr = ^{wb.wbs_adr_i[23:10], wb.wbs_adr_i[1:0]};

  assign sel_hit    = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:24] == MY_HI);
  assign region     = wb.wbs_adr_i[9:8];
  assign idx        = wb.wbs_adr_i[7:2];
  assign idx_ext    = {26'd0, idx};
  assign rd_idx_ext = {26'd0, rd_idx_q};
  assign wmask      = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                       {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};

  // Ack is decoded straight from the state flop, so it is glitch-free and never comb from wbs_*.
  assign wb.wbs_ack_o = (state_q == ST_ACK);
  assign wb.wbs_dat_o = dat_q;
  assign start_o      = start_q;
  assign soft_rst_o   = soft_rst_q;
  assign cfg1_o       = cfg1_q;
  assign cfg2_o       = cfg2_q;
  assign img_we_o     = img_we_q;
  assign kern_we_o    = kern_we_q;
  assign img_addr_o   = img_addr_q;
  assign kern_addr_o  = kern_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign rslt_addr_o  = rslt_addr_q;

  // Next-state, write side effects and read-data capture.
  always_comb begin
    state_d     = state_q;
    dat_d       = dat_q;
    start_d     = start_q;
    soft_rst_d  = soft_rst_q;
    cfg1_d      = cfg1_q;
    cfg2_d      = cfg2_q;
    img_we_d    = 1'b0;
    kern_we_d   = 1'b0;
    img_addr_d  = img_addr_q;
    kern_addr_d = kern_addr_q;
    mem_wdata_d = mem_wdata_q;
    rslt_addr_d = rslt_addr_q;
    rd_region_d = rd_region_q;
    rd_idx_d    = rd_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_hit) begin
          if (wb.wbs_we_i) begin
            state_d = ST_ACK;
            case (region)
              2'd0: begin
                if (idx == 6'd0 && wb.wbs_sel_i[0]) begin
                  soft_rst_d = wb.wbs_dat_i[1];
                  start_d    = wb.wbs_dat_i[2];
                end else if (idx == 6'd1) begin
                  cfg1_d = (cfg1_q & ~wmask) | (wb.wbs_dat_i & wmask);
                end else if (idx == 6'd2) begin
                  cfg2_d = (cfg2_q & ~wmask) | (wb.wbs_dat_i & wmask);
                end
              end
              2'd1: begin
                if (wb.wbs_sel_i[2:0] == 3'b111 && idx_ext < IMG_DEPTH) begin
                  img_we_d    = 1'b1;
                  img_addr_d  = idx_ext[IMG_ADDR_WIDTH-1:0];
                  mem_wdata_d = wb.wbs_dat_i[23:0];
                end
              end
              2'd2: begin
                if (wb.wbs_sel_i[2:0] == 3'b111 && idx_ext < IMG_DEPTH) begin
                  kern_we_d   = 1'b1;
                  kern_addr_d = idx_ext[IMG_ADDR_WIDTH-1:0];
                  mem_wdata_d = wb.wbs_dat_i[23:0];
                end
              end
              default: ;  // result memory is read-only from the bus
            endcase
          end else begin
            // Launch the result address now so the synchronous memory has data by end of RD_WAIT.
            state_d     = ST_RD_WAIT;
            rd_region_d = region;
            rd_idx_d    = idx;
            if (region == 2'd3 && idx_ext < RSLT_DEPTH) begin
              rslt_addr_d = idx_ext[RSLT_ADDR_WIDTH-1:0];
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (!wb.wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
          dat_d   = 32'd0;
          case (rd_region_q)
            2'd0: begin
              case (rd_idx_q)
                6'd0:    dat_d = {29'd0, start_q, soft_rst_q, done_i};
                6'd1:    dat_d = cfg1_q;
                6'd2:    dat_d = cfg2_q;
                default: dat_d = 32'd0;
              endcase
            end
            2'd3: begin
              if (rd_idx_ext < RSLT_DEPTH) dat_d = {24'd0, rslt_rdata_i};
            end
            default: dat_d = 32'd0;
          endcase
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so an in-flight transaction is dropped.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      dat_q       <= 32'd0;
      start_q     <= 1'b0;
      soft_rst_q  <= 1'b0;
      cfg1_q      <= 32'd0;
      cfg2_q      <= 32'd0;
      img_we_q    <= 1'b0;
      kern_we_q   <= 1'b0;
      img_addr_q  <= '0;
      kern_addr_q <= '0;
      mem_wdata_q <= 24'd0;
      rslt_addr_q <= '0;
      rd_region_q <= 2'd0;
      rd_idx_q    <= 6'd0;
    end else begin
      state_q     <= state_d;
      dat_q       <= dat_d;
      start_q     <= start_d;
      soft_rst_q  <= soft_rst_d;
      cfg1_q      <= cfg1_d;
      cfg2_q      <= cfg2_d;
      img_we_q    <= img_we_d;
      kern_we_q   <= kern_we_d;
      img_addr_q  <= img_addr_d;
      kern_addr_q <= kern_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rslt_addr_q <= rslt_addr_d;
      rd_region_q <= rd_region_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

endmodule

// File: tb/tb_conv_wb_slave_if.sv
// Directed bench: two slave instances (INST_NO 0 and 1) sharing one Wishbone request bus.
// Each step drives a request on a falling edge and samples responses on falling edges.
// Every wait for ack is bounded; a missing ack shows up as latency 0xFFFFFFFF.
module tb_conv_wb_slave_if;
  logic clk;
  logic rst_n;

  conv_wb_slave_if_if wb0 ();
  conv_wb_slave_if_if wb1 ();

  // Both slaves observe the same requests; only the decoded one may respond.
  assign wb1.wbs_stb_i = wb0.wbs_stb_i;
  assign wb1.wbs_cyc_i = wb0.wbs_cyc_i;
  assign wb1.wbs_we_i  = wb0.wbs_we_i;
  assign wb1.wbs_sel_i = wb0.wbs_sel_i;
  assign wb1.wbs_dat_i = wb0.wbs_dat_i;
  assign wb1.wbs_adr_i = wb0.wbs_adr_i;

  logic        start0, soft0, img_we0, kern_we0, done0;
  logic [31:0] cfg1_0, cfg2_0;
  logic [4:0]  img_addr0, kern_addr0;
  logic [23:0] wdata0;
  logic [5:0]  rslt_addr0;
  logic [7:0]  rrd0;

  logic        start1, soft1, img_we1, kern_we1, done1;
  logic [31:0] cfg1_1, cfg2_1;
  logic [4:0]  img_addr1, kern_addr1;
  logic [23:0] wdata1;
  logic [5:0]  rslt_addr1;
  logic [7:0]  rrd1;

  conv_wb_slave_if #(.BASE_HI(8'h30), .INST_NO(0), .IMG_ADDR_WIDTH(5), .RSLT_ADDR_WIDTH(6)) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(wb0),
    .start_o(start0), .soft_rst_o(soft0), .cfg1_o(cfg1_0), .cfg2_o(cfg2_0), .done_i(done0),
    .img_we_o(img_we0), .kern_we_o(kern_we0), .img_addr_o(img_addr0), .kern_addr_o(kern_addr0),
    .mem_wdata_o(wdata0), .rslt_addr_o(rslt_addr0), .rslt_rdata_i(rrd0)
  );

  conv_wb_slave_if #(.BASE_HI(8'h30), .INST_NO(1), .IMG_ADDR_WIDTH(5), .RSLT_ADDR_WIDTH(6)) dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(wb1),
    .start_o(start1), .soft_rst_o(soft1), .cfg1_o(cfg1_1), .cfg2_o(cfg2_1), .done_i(done1),
    .img_we_o(img_we1), .kern_we_o(kern_we1), .img_addr_o(img_addr1), .kern_addr_o(kern_addr1),
    .mem_wdata_o(wdata1), .rslt_addr_o(rslt_addr1), .rslt_rdata_i(rrd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          lat;
  logic [31:0] rdat;
  logic        seen1;
  int          acks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request and wait (bounded) for an ack from either slave; request stays asserted.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output int l, output logic [31:0] rd,
                      output logic s1);
    @(negedge clk);
    wb0.wbs_cyc_i = 1'b1;
    wb0.wbs_stb_i = 1'b1;
    wb0.wbs_we_i  = we;
    wb0.wbs_adr_i = adr;
    wb0.wbs_dat_i = dat;
    wb0.wbs_sel_i = sel;
    l  = -1;
    rd = 32'd0;
    s1 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (wb1.wbs_ack_o) s1 = 1'b1;
      if (wb0.wbs_ack_o || wb1.wbs_ack_o) begin
        l  = i;
        rd = wb0.wbs_ack_o ? wb0.wbs_dat_o : wb1.wbs_dat_o;
        break;
      end
    end
  endtask

  task automatic bus_idle();
    wb0.wbs_cyc_i = 1'b0;
    wb0.wbs_stb_i = 1'b0;
    wb0.wbs_we_i  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    rrd0  = 8'h5A;
    rrd1  = 8'h00;
    wb0.wbs_cyc_i = 1'b0;
    wb0.wbs_stb_i = 1'b0;
    wb0.wbs_we_i  = 1'b0;
    wb0.wbs_sel_i = 4'h0;
    wb0.wbs_dat_i = 32'd0;
    wb0.wbs_adr_i = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ack",   {31'd0, wb0.wbs_ack_o}, 32'd0);
    chk("rst_dat",   wb0.wbs_dat_o, 32'd0);
    chk("rst_cfg1",  cfg1_0, 32'd0);
    chk("rst_ctl",   {30'd0, start0, soft0}, 32'd0);
    chk("rst_we",    {30'd0, img_we0, kern_we0}, 32'd0);
    chk("rst_addr",  {21'd0, img_addr0, rslt_addr0}, 32'd0);
    rst_n = 1'b1;

    // cfg1 full-word write, then read back
    xfer(1'b1, 32'h3000_0004, 32'h0103_0702, 4'hF, lat, rdat, seen1);
    chk("cfg1_wr_lat", 32'(lat), 32'd1);
    chk("cfg1_val",    cfg1_0, 32'h0103_0702);
    bus_idle();
    xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, lat, rdat, seen1);
    chk("cfg1_rd_lat", 32'(lat), 32'd2);
    chk("cfg1_rd_dat", rdat, 32'h0103_0702);
    bus_idle();

    // cfg2 byte-lane masked write
    xfer(1'b1, 32'h3000_0008, 32'hFFFF_FFFF, 4'b0001, lat, rdat, seen1);
    chk("cfg2_val", cfg2_0, 32'h0000_00FF);
    bus_idle();

    // Image writes: full select, 3-byte select, partial select
    xfer(1'b1, 32'h3000_0108, 32'h00AB_CDEF, 4'hF, lat, rdat, seen1);
    chk("img_wr_lat", 32'(lat), 32'd1);
    chk("img_we",     {31'd0, img_we0}, 32'd1);
    chk("img_addr",   {27'd0, img_addr0}, 32'd2);
    chk("img_wdata",  {8'd0, wdata0}, 32'h00AB_CDEF);
    bus_idle();
    @(negedge clk);
    chk("img_we_pulse", {31'd0, img_we0}, 32'd0);
    xfer(1'b1, 32'h3000_0108, 32'h00AB_CDEF, 4'b0111, lat, rdat, seen1);
    chk("img7_we",    {31'd0, img_we0}, 32'd1);
    chk("img7_wdata", {8'd0, wdata0}, 32'h00AB_CDEF);
    bus_idle();
    xfer(1'b1, 32'h3000_0104, 32'h0012_3456, 4'b0011, lat, rdat, seen1);
    chk("img3_lat",   32'(lat), 32'd1);
    chk("img3_we",    {31'd0, img_we0}, 32'd0);
    chk("img3_wdata", {8'd0, wdata0}, 32'h00AB_CDEF);
    bus_idle();
    // Word index 32 is beyond a 5-bit image address
    xfer(1'b1, 32'h3000_0180, 32'h0077_7777, 4'hF, lat, rdat, seen1);
    chk("img_oob_lat", 32'(lat), 32'd1);
    chk("img_oob_we",  {31'd0, img_we0}, 32'd0);
    bus_idle();

    // Kernel write
    xfer(1'b1, 32'h3000_0214, 32'h0011_1111, 4'hF, lat, rdat, seen1);
    chk("kern_we",   {31'd0, kern_we0}, 32'd1);
    chk("kern_addr", {27'd0, kern_addr0}, 32'd5);
    chk("kern_img",  {31'd0, img_we0}, 32'd0);
    bus_idle();

    // Result read
    xfer(1'b0, 32'h3000_030C, 32'd0, 4'hF, lat, rdat, seen1);
    chk("rslt_lat",  32'(lat), 32'd2);
    chk("rslt_addr", {26'd0, rslt_addr0}, 32'd3);
    chk("rslt_dat",  rdat, 32'h0000_005A);
    bus_idle();

    // Unmapped register and image read return zero
    xfer(1'b0, 32'h3000_000C, 32'd0, 4'hF, lat, rdat, seen1);
    chk("reg3_lat", 32'(lat), 32'd2);
    chk("reg3_dat", rdat, 32'd0);
    bus_idle();
    xfer(1'b0, 32'h3000_0108, 32'd0, 4'hF, lat, rdat, seen1);
    chk("imgrd_dat", rdat, 32'd0);
    bus_idle();

    // Soft reset bit on instance 0
    xfer(1'b1, 32'h3000_0000, 32'h0000_0002, 4'hF, lat, rdat, seen1);
    chk("soft_rst", {30'd0, start0, soft0}, 32'd1);
    bus_idle();

    // Instance 1 decode
    xfer(1'b1, 32'h3000_0000, 32'h0000_0004, 4'hF, lat, rdat, seen1);
    chk("i1_noack",  {31'd0, seen1}, 32'd0);
    chk("i1_nostart", {31'd0, start1}, 32'd0);
    bus_idle();
    xfer(1'b1, 32'h3100_0000, 32'h0000_0004, 4'hF, lat, rdat, seen1);
    chk("i1_ack",   {31'd0, seen1}, 32'd1);
    chk("i1_start", {31'd0, start1}, 32'd1);
    bus_idle();
    done1 = 1'b1;
    xfer(1'b0, 32'h3100_0000, 32'd0, 4'hF, lat, rdat, seen1);
    chk("i1_rd_lat", 32'(lat), 32'd2);
    chk("i1_rd_dat", rdat, 32'h0000_0005);
    bus_idle();
    xfer(1'b1, 32'h3200_0000, 32'h0000_0004, 4'hF, lat, rdat, seen1);
    chk("nodecode_lat", 32'(lat), 32'hFFFF_FFFF);
    bus_idle();

    // Master abandons a read while it waits
    @(negedge clk);
    wb0.wbs_cyc_i = 1'b1;
    wb0.wbs_stb_i = 1'b1;
    wb0.wbs_we_i  = 1'b0;
    wb0.wbs_adr_i = 32'h3000_030C;
    @(negedge clk);
    bus_idle();
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb0.wbs_ack_o) acks++;
    end
    chk("abort_noack", 32'(acks), 32'd0);

    // Reset during RD_WAIT
    rrd0 = 8'h3C;
    @(negedge clk);
    wb0.wbs_cyc_i = 1'b1;
    wb0.wbs_stb_i = 1'b1;
    wb0.wbs_adr_i = 32'h3000_030C;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dat",  wb0.wbs_dat_o, 32'd0);
    chk("mid_rst_cfg",  cfg1_0 | cfg2_0, 32'd0);
    chk("mid_rst_ctl",  {28'd0, start1, soft0, start0, rslt_addr0 != 6'd0}, 32'd0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb0.wbs_ack_o) acks++;
    end
    chk("mid_rst_noack", 32'(acks), 32'd0);
    bus_idle();
    rst_n = 1'b1;
    xfer(1'b0, 32'h3000_030C, 32'd0, 4'hF, lat, rdat, seen1);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_dat", rdat, 32'h0000_003C);
    bus_idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
